// File: rtl/sram_pattern_tester.sv
// sram_pattern_tester: writes an address-derived pattern over 0..2^TEST_ALOG2-1, reads it back and counts mismatches
module sram_pattern_tester #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int TEST_ALOG2 = 14,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  sram_req,
  output logic                  sram_rh_wl,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_w,
  input  logic [DATA_WIDTH-1:0] sram_data_r,
  input  logic                  sram_data_r_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  localparam int PW = TEST_ALOG2 > DATA_WIDTH ? TEST_ALOG2 : DATA_WIDTH;
  state_t                  state_q, state_d;
  logic [TEST_ALOG2-1:0]   cnt_q, cnt_d, exp_addr_q;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [ERR_WIDTH-1:0]    err_d;
  logic [ADDR_WIDTH-1:0]   first_d;
  logic                    rd_pend_q, accept, last, mismatch, req_d;
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [TEST_ALOG2-1:0] a,
                                                input logic [DATA_WIDTH-1:0] s);
    logic [PW-1:0] x;
    x = PW'(a);
    return DATA_WIDTH'(x ^ (x >> DATA_WIDTH)) ^ s;
  endfunction
  // Request outputs are registered from next-state so they line up with the state they belong to
  always_comb begin
    accept   = start && (state_q == IDLE || state_q == DONE);
    last     = &cnt_q;
    seed_d   = accept ? seed : seed_q;
    cnt_d    = accept ? '0 : (state_q == WRITE || state_q == READ) ? cnt_q + 1'b1 : cnt_q;
    state_d  = accept ? WRITE :
               state_q == WRITE && last ? READ :
               state_q == READ && last ? DRAIN :
               state_q == DRAIN ? DONE : state_q;
    mismatch = sram_data_r_en && rd_pend_q && sram_data_r != pat(exp_addr_q, seed_q);
    err_d    = accept ? '0 : mismatch && !(&err_count) ? err_count + 1'b1 : err_count;
    first_d  = accept ? '0 : mismatch && err_count == '0 ? ADDR_WIDTH'(exp_addr_q) : first_err_addr;
    req_d    = state_d == WRITE || state_d == READ;
  end
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      seed_q         <= '0;
      exp_addr_q     <= '0;
      rd_pend_q      <= 1'b0;
      sram_req       <= 1'b0;
      sram_rh_wl     <= 1'b0;
      sram_addr      <= '0;
      sram_data_w    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seed_q         <= seed_d;
      exp_addr_q     <= state_q == READ ? cnt_q : exp_addr_q;
      rd_pend_q      <= state_q == READ;
      sram_req       <= req_d;
      sram_rh_wl     <= state_d == READ;
      sram_addr      <= req_d ? ADDR_WIDTH'(cnt_d) : '0;
      sram_data_w    <= state_d == WRITE ? pat(cnt_d, seed_d) : '0;
      busy           <= state_d == WRITE || state_d == READ || state_d == DRAIN;
      done           <= state_q == DONE && !accept;
      pass           <= state_q == DONE && !accept && err_d == '0;
      err_count      <= err_d;
      first_err_addr <= first_d;
    end
  end
endmodule

// File: tb/tb_sram_pattern_tester.sv
// tb_sram_pattern_tester: scoreboard bench with a 1-cycle-latency memory model and fault injection
module tb_sram_pattern_tester;
  localparam int AW = 19, DW = 8, TA = 4, EW = 16, N = 16;
  typedef struct {logic rh; logic [AW-1:0] addr; logic [DW-1:0] data;} op_t;
  typedef struct {int start_cyc; logic [EW-1:0] err; logic [AW-1:0] first; logic pass;} res_t;
  logic clk = 0, reset_l = 0, start = 0;
  logic [DW-1:0] seed = '0;
  logic sram_req, sram_rh_wl, busy, done, pass;
  logic [AW-1:0] sram_addr, first_err_addr;
  logic [DW-1:0] sram_data_w;
  logic [DW-1:0] sram_data_r = '0;
  logic sram_data_r_en = 0;
  logic [EW-1:0] err_count;
  logic [DW-1:0] mem [N];
  logic [N-1:0] fault = '0;
  int tests = 0, fails = 0, cyc = 0;
  op_t exp_ops[$];
  res_t exp_res[$];

  sram_pattern_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TEST_ALOG2(TA), .ERR_WIDTH(EW)) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .seed(seed),
    .sram_req(sram_req), .sram_rh_wl(sram_rh_wl), .sram_addr(sram_addr),
    .sram_data_w(sram_data_w), .sram_data_r(sram_data_r), .sram_data_r_en(sram_data_r_en),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory answers every request one cycle later; write strobes return junk data
  always @(posedge clk) begin
    if (sram_req) begin
      sram_data_r_en <= 1'b1;
      if (!sram_rh_wl) begin
        mem[sram_addr[TA-1:0]] <= sram_data_w;
        sram_data_r <= DW'($urandom);
      end else
        sram_data_r <= mem[sram_addr[TA-1:0]] ^ {{(DW-1){1'b0}}, fault[sram_addr[TA-1:0]]};
    end else
      sram_data_r_en <= 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat_ref(input int a, input logic [DW-1:0] s);
    int x;
    x = (a ^ (a >> DW)) & 255;
    return DW'(x) ^ s;
  endfunction

  initial begin
    op_t o;
    res_t r;
    logic pd;
    pd = 0;
    forever begin
      @(negedge clk);
      if (!reset_l) begin
        pd = 0;
        continue;
      end
      if (sram_req) begin
        if (exp_ops.size() == 0) check("unexpected_req", 1, 0);
        else begin
          o = exp_ops.pop_front();
          check("req_dir", sram_rh_wl, o.rh);
          check("req_addr", sram_addr, o.addr);
          if (!o.rh) check("wr_data", sram_data_w, o.data);
        end
      end else begin
        check("idle_addr", sram_addr, 0);
        check("idle_data", sram_data_w, 0);
      end
      if (done && !pd) begin
        if (exp_res.size() == 0) check("unexpected_done", 1, 0);
        else begin
          r = exp_res.pop_front();
          check("done_latency", cyc - r.start_cyc, 2 * N + 2);
          check("err_count", err_count, r.err);
          check("first_err_addr", first_err_addr, r.first);
          check("pass", pass, r.pass);
          check("busy_at_done", busy, 0);
        end
      end
      pd = done;
    end
  end

  task automatic run(input logic [DW-1:0] s, input logic [N-1:0] f);
    res_t r;
    int n, first;
    n = 0;
    first = -1;
    fault = f;
    for (int a = 0; a < N; a++) exp_ops.push_back('{1'b0, AW'(a), pat_ref(a, s)});
    for (int a = 0; a < N; a++) exp_ops.push_back('{1'b1, AW'(a), '0});
    for (int a = 0; a < N; a++) if (f[a]) begin
      n++;
      if (first < 0) first = a;
    end
    @(negedge clk);
    seed = s;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    r.start_cyc = cyc;
    r.err = EW'(n);
    r.first = first < 0 ? '0 : AW'(first);
    r.pass = n == 0;
    exp_res.push_back(r);
    @(negedge clk);
    check("start_clears_done", done, 0);
    check("start_clears_err", err_count, 0);
    check("start_clears_first", first_err_addr, 0);
    check("start_sets_busy", busy, 1);
  endtask

  task automatic wait_done(input logic [DW-1:0] s);
    int t;
    t = 0;
    while (exp_res.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_res.size() != 0) begin
      check("run_timeout", 1, 0);
      exp_res.delete();
      exp_ops.delete();
    end
    for (int a = 0; a < N; a++) check("mem_content", mem[a], pat_ref(a, s));
  endtask

  initial begin
    int t;
    logic [DW-1:0] s;
    reset_l = 0;
    start = 1;
    seed = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_req", sram_req, 0);
    check("rst_rh", sram_rh_wl, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_data", sram_data_w, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_addr, 0);
    start = 0;
    reset_l = 1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    run(8'h00, '0);
    wait_done(8'h00);
    run(8'hA5, N'(1) << 5);
    wait_done(8'hA5);
    s = DW'($urandom);
    run(s, (N'(1) << 3) | (N'(1) << 9));
    wait_done(s);

    s = DW'($urandom);
    run(s, '0);
    t = 0;
    while (!(sram_req && sram_rh_wl) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reached_read", sram_rh_wl, 1);
    start = 1;
    seed = ~s;
    @(negedge clk);
    start = 0;
    wait_done(s);

    s = DW'($urandom);
    run(s, '0);
    t = 0;
    while (!(sram_req && sram_rh_wl && sram_addr == 7) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reached_read7", sram_addr, 7);
    #1 reset_l = 0;
    exp_ops.delete();
    exp_res.delete();
    #1;
    check("midrst_req", sram_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    reset_l = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_no_req", sram_req, 0);
      check("postrst_busy", busy, 0);
    end
    s = DW'($urandom);
    run(s, '0);
    wait_done(s);

    for (int i = 0; i < 4; i++) begin
      s = DW'($urandom);
      run(s, N'($urandom) & N'($urandom));
      wait_done(s);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
